// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-logic adder scheduler: datapath width,
// default requester count and the scheduler FSM encoding.
package snake_pkg;
  localparam int WORD_W        = 5;
  localparam int N_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Requester-side bus of the shared-adder scheduler. Clients drive REQ/OPA/OPB
// (master); the scheduler drives grant, result and status (slave).
interface adder_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  import snake_pkg::*;

  // REQ[i] is held with stable operands until GNT[i] is seen; the client drops
  // it at the edge that samples GNT[i]=1, and the result arrives one cycle later.
  logic [N_REQ-1:0]        REQ;
  logic [WORD_W*N_REQ-1:0] OPA;
  logic [WORD_W*N_REQ-1:0] OPB;
  logic [N_REQ-1:0]        GNT;
  logic [WORD_W-1:0]       RESULT;
  logic                    RESULT_VALID;
  logic [ID_W-1:0]         RESULT_ID;
  logic                    BUSY;

  modport master (
    output REQ, OPA, OPB,
    input  GNT, RESULT, RESULT_VALID, RESULT_ID, BUSY
  );

  modport slave (
    input  REQ, OPA, OPB,
    output GNT, RESULT, RESULT_VALID, RESULT_ID, BUSY
  );
endinterface

// File: rtl/fiveBitAdder.sv
// The single shared 5-bit adder; carry out is discarded so sums wrap mod 32.
module fiveBitAdder
  import snake_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping, as both a one-hot vector and a binary index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);
  always_comb begin
    int  j;
    logic found;
    j       = 0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        idx_o      = ID_W'(j);
        grant_o[j] = 1'b1;
      end
    end
    any_o = found;
  end
endmodule

// File: rtl/adder_rr_scheduler.sv
// Time-shares one fiveBitAdder between N_REQ requesters: arbitrate in IDLE,
// grant and add in CALC, present the registered result in RESP.
module adder_rr_scheduler
  import snake_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int ID_W  = 2
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  adder_rr_scheduler_if.slave  bus
);
  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WORD_W-1:0] opa_q, opa_d;
  logic [WORD_W-1:0] opb_q, opb_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [ID_W-1:0]   rid_q, rid_d;

  logic [N_REQ-1:0]  win_onehot;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic [WORD_W-1:0] opa_sel, opb_sel;
  logic [WORD_W-1:0] sum;
  logic [N_REQ-1:0]  gnt;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i   (bus.REQ),
    .ptr_i   (ptr_q),
    .grant_o (win_onehot),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  fiveBitAdder u_add (
    .a_i   (opa_q),
    .b_i   (opb_q),
    .sum_o (sum)
  );

  always_comb begin
    opa_sel = '0;
    opb_sel = '0;
    gnt     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        opa_sel = bus.OPA[i*WORD_W +: WORD_W];
        opb_sel = bus.OPB[i*WORD_W +: WORD_W];
      end
      gnt[i] = (state_q == CALC) && (id_q == ID_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    rid_d    = rid_q;
    case (state_q)
      IDLE: begin
        // Operands are captured only here; later changes on the bus are ignored.
        if (win_any) begin
          state_d = CALC;
          id_d    = win_idx;
          opa_d   = opa_sel;
          opb_d   = opb_sel;
        end
      end
      CALC: begin
        state_d  = RESP;
        result_d = sum;
        rid_d    = id_q;
        ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      rid_q    <= rid_d;
    end
  end

  assign bus.GNT          = gnt;
  assign bus.RESULT       = result_q;
  assign bus.RESULT_ID    = rid_q;
  assign bus.RESULT_VALID = (state_q == RESP);
  assign bus.BUSY         = (state_q != IDLE);
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: expected sums are queued when a request
// is raised and compared when RESULT_VALID appears.
module tb_adder_rr_scheduler;
  import snake_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = IW + WORD_W;

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  adder_rr_scheduler_if #(.N_REQ(N), .ID_W(IW)) bus ();
  adder_rr_scheduler #(.N_REQ(N), .ID_W(IW)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  longint t_now, t_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int idx, input int a, input int b);
    exp_q.push_back({IW'(idx), WORD_W'((a + b) % 32)});
  endfunction

  task automatic set_op(input int idx, input int a, input int b);
    bus.OPA[idx*WORD_W +: WORD_W] = WORD_W'(a);
    bus.OPB[idx*WORD_W +: WORD_W] = WORD_W'(b);
  endtask

  task automatic wait_gnt(input int idx);
    int n;
    n = 0;
    @(negedge CLK);
    while (bus.GNT === '0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check($sformatf("gnt_req%0d", idx), 32'(bus.GNT), 32'(1 << idx));
    check("busy_in_calc", 32'(bus.BUSY), 32'd1);
  endtask

  task automatic drop(input int idx);
    @(posedge CLK);
    #1 bus.REQ[idx] = 1'b0;
  endtask

  task automatic do_op(input int idx, input int a, input int b);
    @(posedge CLK);
    #1;
    set_op(idx, a, b);
    bus.REQ[idx] = 1'b1;
    push_exp(idx, a, b);
    wait_gnt(idx);
    drop(idx);
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (RESETN && bus.RESULT_VALID === 1'b1) begin
      check("result_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", 32'(bus.RESULT), 32'(e[WORD_W-1:0]));
        check("result_id", 32'(bus.RESULT_ID), 32'(e[W-1:WORD_W]));
      end
    end
  end

  initial begin
    bus.REQ = '0;
    bus.OPA = '0;
    bus.OPB = '0;
    RESETN  = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_gnt", 32'(bus.GNT), 32'd0);
    check("rst_result", 32'(bus.RESULT), 32'd0);
    check("rst_valid", 32'(bus.RESULT_VALID), 32'd0);
    check("rst_id", 32'(bus.RESULT_ID), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    RESETN = 1'b1;

    // Single request: 3+4, grant one cycle after sampling, result the next.
    @(posedge CLK);
    #1;
    set_op(0, 3, 4);
    bus.REQ[0] = 1'b1;
    push_exp(0, 3, 4);
    @(negedge CLK);
    check("t1_idle_gnt", 32'(bus.GNT), 32'd0);
    check("t1_idle_busy", 32'(bus.BUSY), 32'd0);
    wait_gnt(0);
    drop(0);
    @(negedge CLK);
    check("t1_valid", 32'(bus.RESULT_VALID), 32'd1);
    check("t1_busy_resp", 32'(bus.BUSY), 32'd1);
    @(negedge CLK);
    check("t1_valid_pulse", 32'(bus.RESULT_VALID), 32'd0);
    check("t1_busy_done", 32'(bus.BUSY), 32'd0);
    check("t1_gnt_done", 32'(bus.GNT), 32'd0);
    check("t1_result_hold", 32'(bus.RESULT), 32'd7);

    // Wrap-around sums.
    do_op(1, 31, 1);
    do_op(3, 20, 15);

    // Contention: all four held, pointer back at 0 -> grants 0..3, 30 ns apart.
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      set_op(i, i + 1, i + 1);
      push_exp(i, i + 1, i + 1);
    end
    bus.REQ = 4'b1111;
    t_last = 0;
    for (int i = 0; i < N; i++) begin
      wait_gnt(i);
      t_now = $time;
      if (i > 0) check($sformatf("t3_gap%0d", i), 32'(t_now - t_last), 32'd30);
      t_last = t_now;
      drop(i);
    end
    @(negedge CLK);

    // Fairness: req0 keeps requesting, req2 joins; pointer=1 so req2 goes first.
    @(posedge CLK);
    #1;
    set_op(0, 5, 5);
    bus.REQ[0] = 1'b1;
    push_exp(0, 5, 5);
    wait_gnt(0);
    @(posedge CLK);
    #1;
    set_op(0, 2, 2);
    set_op(2, 7, 8);
    bus.REQ[2] = 1'b1;
    push_exp(2, 7, 8);
    push_exp(0, 2, 2);
    wait_gnt(2);
    drop(2);
    wait_gnt(0);
    drop(0);
    @(negedge CLK);

    // Operand change after capture is ignored.
    @(posedge CLK);
    #1;
    set_op(1, 10, 9);
    bus.REQ[1] = 1'b1;
    push_exp(1, 10, 9);
    wait_gnt(1);
    set_op(1, 30, 9);
    drop(1);
    @(negedge CLK);

    // Reset during CALC aborts the op; then a fresh request to requester 2.
    @(posedge CLK);
    #1;
    set_op(1, 5, 6);
    bus.REQ[1] = 1'b1;
    wait_gnt(1);
    #1;
    RESETN  = 1'b0;
    bus.REQ = '0;
    #1;
    check("t5_rst_gnt", 32'(bus.GNT), 32'd0);
    check("t5_rst_valid", 32'(bus.RESULT_VALID), 32'd0);
    check("t5_rst_busy", 32'(bus.BUSY), 32'd0);
    check("t5_rst_result", 32'(bus.RESULT), 32'd0);
    @(negedge CLK);
    check("t5_in_rst_valid", 32'(bus.RESULT_VALID), 32'd0);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    set_op(2, 9, 9);
    bus.REQ[2] = 1'b1;
    push_exp(2, 9, 9);
    @(negedge CLK);
    check("t5_idle_gnt", 32'(bus.GNT), 32'd0);
    @(negedge CLK);
    check("t5_gnt", 32'(bus.GNT), 32'b0100);
    drop(2);
    @(negedge CLK);
    check("t5_valid", 32'(bus.RESULT_VALID), 32'd1);
    @(negedge CLK);
    check("t5_valid_pulse", 32'(bus.RESULT_VALID), 32'd0);

    repeat (2) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
